// File: rtl/seq_scan_ctrl_if.sv
// Requester-side handshake and scan result bundle for seq_scan_ctrl.
// The requester (master) offers a word; the controller (slave) shifts it out
// serially and reports match pulses, a per-word match count and a done pulse.
interface seq_scan_ctrl_if #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
);
   logic              start_valid;
   logic              start_ready;
   logic [WORD_W-1:0] word_in;
   logic              bit_out;
   logic              bit_valid;
   logic              match_pulse;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  match_count;

   modport master (
      output start_valid,
      output word_in,
      input  start_ready,
      input  bit_out,
      input  bit_valid,
      input  match_pulse,
      input  busy,
      input  done,
      input  match_count
   );

   modport slave (
      input  start_valid,
      input  word_in,
      output start_ready,
      output bit_out,
      output bit_valid,
      output match_pulse,
      output busy,
      output done,
      output match_count
   );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Scan controller for the serial pattern detectors.
// Accepts a parallel word over a valid/ready handshake, shifts it out MSB-first
// one bit per clock, and runs an overlapping Mealy match against PATTERN.
// Match history is cleared for every word, so matches never span two words.
module seq_scan_ctrl #(
   parameter int               WORD_W  = 8,
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
   parameter int               CNT_W   = 4
) (
   input logic           clock,
   input logic           reset,
   seq_scan_ctrl_if.slave bus
);

   localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int FILL_W = $clog2(PAT_W);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]        state;
   logic [WORD_W-1:0] wordReg;
   logic [IDX_W-1:0]  bitIdx;
   logic [PAT_W-2:0]  history;
   logic [FILL_W-1:0] fillCount;
   logic [CNT_W-1:0]  matchCount;

   logic              curBit;
   logic [PAT_W-1:0]  window;
   logic              hitNow;
   logic              acceptWord;

   assign acceptWord = (state == IDLE) && bus.start_valid;

   assign curBit = (state == SHIFT) ? wordReg[bitIdx] : 1'b0;
   assign window = {history, curBit};
   assign hitNow = (state == SHIFT) && (window == PATTERN) && (fillCount >= FILL_FULL);

   assign bus.start_ready = (state == IDLE);
   assign bus.bit_out     = curBit;
   assign bus.bit_valid   = (state == SHIFT);
   assign bus.match_pulse = hitNow;
   assign bus.busy        = (state == SHIFT) || (state == DONE);
   assign bus.done        = (state == DONE);
   assign bus.match_count = matchCount;

   // Sequencer: capture the word on handshake, walk the bit index down to 0, pulse DONE once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wordReg <= '0;
         bitIdx  <= LAST_IDX;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_valid) begin
                  wordReg <= bus.word_in;
                  bitIdx  <= LAST_IDX;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (bitIdx == '0) begin
                  state <= DONE;
               end else begin
                  bitIdx <= bitIdx - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pattern history: restart empty for each word, then track the last PAT_W-1 bits and how many are valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         history   <= '0;
         fillCount <= '0;
      end else if (acceptWord) begin
         history   <= '0;
         fillCount <= '0;
      end else if (state == SHIFT) begin
         history <= window[PAT_W-2:0];
         if (fillCount != FILL_FULL) begin
            fillCount <= fillCount + 1'b1;
         end
      end
   end

   // Match counter: cleared on a new word, saturating increment per match, held after DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         matchCount <= '0;
      end else if (acceptWord) begin
         matchCount <= '0;
      end else if (hitNow && (matchCount != CNT_MAX)) begin
         matchCount <= matchCount + 1'b1;
      end
   end

endmodule
